uart_rx_core: RTL

- UART receive engine for the full-duplex UART IP.
- Sits directly downstream of the RX baud generator. It consumes that generator's baud_clk, a 16x-oversample square wave toggled in the clk domain, as a sampled enable, never as a clock.
- Synchronises the serial rx line, detects and validates the start bit, samples data, parity and stop bits at mid-bit, and presents each byte with a one-cycle valid strobe and error flags.
- The only clock is clk; the bus side of the UART consumes rx_data/rx_valid.

---
 rtl/uart_rx_core.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises rx, validates the start bit, samples data/parity/stop
// at mid-bit on ticks derived from the baud_clk rising edge, and strobes each frame out.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_clk,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, next_state;
  logic                   rx_meta, rx_s, baud_prev, tick;
  logic                   mid_hit, end_hit;
  logic                   shift_en, par_sample, frame_done;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;

  // rx is asynchronous; baud_clk is only ever used as an edge-detected enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      baud_prev <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      baud_prev <= baud_clk;
    end
  end

  assign tick    = baud_clk & ~baud_prev;
  assign mid_hit = tick && (tick_cnt == MID_CNT);
  assign end_hit = tick && (tick_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (mid_hit) next_state = rx_s ? IDLE : DATA;
      DATA:    if (end_hit && (bit_cnt == LAST_BIT)) next_state = parity_en ? PARITY : STOP;
      PARITY:  if (end_hit) next_state = STOP;
      STOP:    if (end_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rx_busy    = (state != IDLE);
    shift_en   = (state == DATA)   && end_hit;
    par_sample = (state == PARITY) && end_hit;
    frame_done = (state == STOP)   && end_hit;
  end

  // Both counters restart on every state change so each state measures from its own entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state != next_state) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (tick) tick_cnt <= (tick_cnt == LAST_CNT) ? '0 : tick_cnt + TW'(1);
      if (shift_en) bit_cnt <= bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (shift_en)   shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
      if (par_sample) par_bit <= rx_s;
    end
  end

  // Results update together with the one-cycle strobe and hold until the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= frame_done;
      if (frame_done) begin
        rx_data    <= shreg;
        frame_err  <= ~rx_s;
        parity_err <= parity_en & (^shreg ^ par_bit ^ parity_odd);
      end
    end
  end

endmodule
